sat_accum: RTL

SAT_ACCUM -- requirements
Module: sat_accum

---
 rtl/sat_pkg.sv | 25 ++
 rtl/sat_lane.sv | 44 ++++
 rtl/sat_accum.sv | 70 +++++++
 3 files changed

// File: rtl/sat_pkg.sv
// Shared definitions for the saturating accumulator: operation codes and
// per-width saturation limits.
package sat_pkg;

    typedef enum logic [1:0] {
        OP_CLEAR = 2'd0,
        OP_LOAD  = 2'd1,
        OP_ADD   = 2'd2,
        OP_SUB   = 2'd3
    } op_e;

    // Limits are returned as 64-bit patterns; callers cast down to their width.
    function automatic logic [63:0] smax(input int width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(input int width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic logic [63:0] umax(input int width);
        return (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
    endfunction

endpackage

// File: rtl/sat_lane.sv
// One accumulator lane: add or subtract at WIDTH+1 bits, then clamp to the
// signed or unsigned range. Purely combinational.
module sat_lane
    import sat_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             is_signed,
    output logic [WIDTH-1:0] result,
    output logic             sat
);

    localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
    localparam logic [WIDTH-1:0] UMAX = WIDTH'(umax(WIDTH));

    logic [WIDTH:0] ext_a;
    logic [WIDTH:0] ext_b;
    logic [WIDTH:0] sum;

    // The extra bit holds every signed sum/difference exactly (including
    // 0 - MIN), so overflow shows as the top two bits disagreeing; in
    // unsigned mode the top bit is the carry or borrow.
    always_comb begin
        ext_a  = {is_signed & a[WIDTH-1], a};
        ext_b  = {is_signed & b[WIDTH-1], b};
        sum    = sub ? (ext_a - ext_b) : (ext_a + ext_b);
        result = sum[WIDTH-1:0];
        sat    = 1'b0;
        if (is_signed) begin
            if (sum[WIDTH] != sum[WIDTH-1]) begin
                sat    = 1'b1;
                result = sum[WIDTH] ? SMIN : SMAX;
            end
        end else if (sum[WIDTH]) begin
            sat    = 1'b1;
            result = sub ? '0 : UMAX;
        end
    end

endmodule

// File: rtl/sat_accum.sv
// Multi-lane saturating accumulator with per-lane pulse and sticky
// saturation flags. All state lives here; lanes are combinational.
module sat_accum
    import sat_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [1:0]             op,
    input  logic                   is_signed,
    input  logic [LANES*WIDTH-1:0] in_data,
    input  logic                   flag_clr,
    output logic [LANES*WIDTH-1:0] acc,
    output logic                   out_valid,
    output logic [LANES-1:0]       sat_pulse,
    output logic [LANES-1:0]       sat_sticky
);

    op_e                    op_q;
    logic                   is_sub;
    logic                   is_arith;
    logic [LANES*WIDTH-1:0] lane_res;
    logic [LANES-1:0]       lane_sat;
    logic [LANES-1:0]       new_sat;

    assign op_q     = op_e'(op);
    assign is_sub   = (op_q == OP_SUB);
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);
    assign new_sat  = (in_valid && is_arith) ? lane_sat : '0;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        sat_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .a        (acc[i*WIDTH +: WIDTH]),
            .b        (in_data[i*WIDTH +: WIDTH]),
            .sub      (is_sub),
            .is_signed(is_signed),
            .result   (lane_res[i*WIDTH +: WIDTH]),
            .sat      (lane_sat[i])
        );
    end

    // Register the selected operation result and flags; a fresh saturation
    // overrides a simultaneous flag clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc        <= '0;
            out_valid  <= 1'b0;
            sat_pulse  <= '0;
            sat_sticky <= '0;
        end else begin
            out_valid  <= in_valid;
            sat_pulse  <= new_sat;
            sat_sticky <= (flag_clr ? '0 : sat_sticky) | new_sat;
            if (in_valid) begin
                unique case (op_q)
                    OP_CLEAR: acc <= '0;
                    OP_LOAD:  acc <= in_data;
                    OP_ADD,
                    OP_SUB:   acc <= lane_res;
                endcase
            end
        end
    end

endmodule
